y_seq_detect: RTL and testbench
===============================

Name: y_seq_detect

Overview:
- Downstream consumer of the comb_str selector output y.
- Samples y as a serial bit stream, one bit per qualified clock.
- Detects the fixed pattern 1101, pulses a match flag, keeps a saturating match count and a shift history of recent bits for debug and scoring.
- Sits between the combinational datapath under test and the result/display logic.

Parameters:
- CNT_W, 8: width of the match counter.
- HIST_W, 8: depth of the bit-history shift register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit (the y output of comb_str).
- din_vld  input  1  din is sampled only when high.
- clr  input  1  synchronous clear of state, count, history and match.
- match  output  1  registered one-cycle pulse per detected pattern.
- match_cnt  output  CNT_W  number of matches since reset/clr; saturates.
- hist  output  HIST_W  last HIST_W accepted bits; bit 0 is newest.
- state_o  output  2  current FSM state encoding, for observation.

Behaviour:
- Reset (rst_n low, asynchronous): state=S0, match=0, match_cnt=0, hist=0, state_o=S0.
- Accepted bit: rising edge with din_vld=1 and clr=0. Cycles with din_vld=0 leave state, hist and count unchanged and drive match=0.
- FSM, encoding S0=0, S1=1, S11=2, S110=3 (prefix matched so far):
  - S0: din=1 -> S1; din=0 -> S0.
  - S1: 1 -> S11; 0 -> S0.
  - S11: 1 -> S11; 0 -> S110.
  - S110: 1 -> detect, next state per Optional Feature; 0 -> S0.
- Detect latency: match goes high in the cycle after the edge that accepts the final 1, then low unless another detect occurs. Back-to-back detects are impossible, because the minimum spacing is 3 accepted bits.
- match_cnt increments on the same edge that sets match. At 2^CNT_W-1 it holds its value, with no wrap.
- hist shifts on every accepted bit: hist <= {hist[HIST_W-2:0], din}.
- clr=1 takes priority over din_vld: the bit is discarded; state=S0, match=0, match_cnt=0, hist=0 on that edge.
- Reset mid-sequence discards the partial prefix; detection restarts from S0.
- din=X with din_vld=1 is not required to be handled. The bench drives din_vld=0 until the upstream inputs are known.
- state_o is the registered state.

Optional Feature:
- Macro: Y_SEQ_OVERLAP_EN.
- Defined: on detect the FSM goes to S1, so the trailing 1 seeds the next match. 1101101 yields 2 matches.
- Undefined: on detect the FSM goes to S0, giving non-overlapping detection. 1101101 yields 1 match.

Decomposition:
- Shared package/header y_seq_defs holds:
  - state localparams S0/S1/S11/S110;
  - state width 2;
  - pattern constant 4'b1101 (documentation and bench reference model).
- One natural sub-module: sat_counter, a CNT_W-wide saturating counter with enable and synchronous clear, async active-low reset. It is instantiated for match_cnt.
- FSM and history register stay in the top.

Test Plan:
- Reset check: rst_n low 3 cycles with din toggling -> match=0, match_cnt=0, hist=0, state_o=0 throughout; release -> still 0 until bits are accepted.
- Single pattern: din_vld=1, din=1,1,0,1 -> match high exactly one cycle after the 4th bit; match_cnt=1; hist[3:0]=4'b1101.
- Overlap: din=1,1,0,1,1,0,1 -> 2 pulses with Y_SEQ_OVERLAP_EN, match_cnt=2; without it, 1 pulse, match_cnt=1.
- Gaps: 1,1,(din_vld=0 for 5 cycles, din=0),0,1 -> one match; hist unchanged during gaps; state_o holds S11 through the gap.
- Saturation: CNT_W=2, six non-overlapping 1101 groups -> match_cnt goes 1,2,3,3,3,3; match still pulses 6 times.
- Clear/reset collisions:
  - clr=1 on the edge of the final 1 of 1101 -> no match, cnt=0, state S0.
  - rst_n low after 1,1,0 then bits 1,1,0,1 -> exactly one match.

Source files
------------

// File: rtl/y_seq_detect_pkg.sv
// Shared definitions for the 1101 serial pattern detector: state encoding and pattern.
// Y_SEQ_OVERLAP_EN selects overlapping detection (post-detect state S1 instead of S0).
package y_seq_defs;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S11  = 2'd2,
    S110 = 2'd3
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1101;

  // The trailing 1 of a match is also a valid one-bit prefix of the next match.
`ifdef Y_SEQ_OVERLAP_EN
  localparam state_e DETECT_NEXT = S1;
`else
  localparam state_e DETECT_NEXT = S0;
`endif

endpackage

// File: rtl/y_seq_detect_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/y_seq_detect.sv
// Serial 1101 detector on the comb_str y stream: match pulse, saturating count, bit history.
// Build option: define Y_SEQ_OVERLAP_EN for overlapping detection.
module y_seq_detect
  import y_seq_defs::*;
#(
  parameter int CNT_W  = 8,
  parameter int HIST_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_vld,
  input  logic              clr,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [HIST_W-1:0] hist,
  output logic [STATE_W-1:0] state_o
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_accept;
  logic              w_detect;
  logic              r_match;
  logic [HIST_W-1:0] r_hist;

  assign w_accept = din_vld & ~clr;

  // NOTE: defaults first so every path assigns every output; no latches inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_detect    = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        S0:   w_state_nxt = din ? S1 : S0;
        S1:   w_state_nxt = din ? S11 : S0;
        S11:  w_state_nxt = din ? S11 : S110;
        S110: begin
          if (din) begin
            w_detect    = 1'b1;
            w_state_nxt = DETECT_NEXT;
          end else begin
            w_state_nxt = S0;
          end
        end
        default: w_state_nxt = S0;
      endcase
    end
  end

  // NOTE: all control state here is small and observable, so every flop gets
  // the async reset; clr is the synchronous equivalent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S0;
      r_match <= 1'b0;
      r_hist  <= '0;
    end else if (clr) begin
      r_state <= S0;
      r_match <= 1'b0;
      r_hist  <= '0;
    end else begin
      r_match <= w_detect;
      if (w_accept) begin
        r_state <= w_state_nxt;
        r_hist  <= {r_hist[HIST_W-2:0], din};
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (clr),
    .i_en  (w_detect),
    .o_cnt (match_cnt)
  );

  assign match   = r_match;
  assign hist    = r_hist;
  assign state_o = r_state;

endmodule

// File: tb/tb_y_seq_detect.sv
// Self-checking bench for y_seq_detect: vector table, directed corner sequences and
// randomized stimulus against a suffix-matching reference model.
module tb_y_seq_detect;
  import y_seq_defs::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_vld = 1'b0;
  logic       clr = 1'b0;
  logic       match, match_s;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_s;
  logic [7:0] hist, hist_s;
  logic [1:0] state_o, state_o_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  y_seq_detect dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
    .match(match), .match_cnt(match_cnt), .hist(hist), .state_o(state_o)
  );

  y_seq_detect #(.CNT_W(2), .HIST_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
    .match(match_s), .match_cnt(match_cnt_s), .hist(hist_s), .state_o(state_o_s)
  );

`ifdef Y_SEQ_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  // Reference model: bits accepted since the last restart point, scanned as a string.
  bit       m_bits[$];
  bit [7:0] m_hist;
  int       m_cnt, m_cnt_sat, m_state;
  bit       m_match;

  function automatic bit tail_is_prefix(int k);
    logic [3:0] pat;
    pat = PATTERN;
    if (k > m_bits.size()) return 1'b0;
    for (int i = 0; i < k; i++)
      if (m_bits[m_bits.size() - k + i] != pat[3 - i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_hist = '0; m_cnt = 0; m_cnt_sat = 0; m_state = 0; m_match = 1'b0;
  endtask

  task automatic model_edge(bit d, bit v, bit c);
    m_match = 1'b0;
    if (c) begin
      model_reset();
      return;
    end
    if (!v) return;
    m_bits.push_back(d);
    m_hist = {m_hist[6:0], d};
    if (tail_is_prefix(4)) begin
      m_match = 1'b1;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt_sat < 3) m_cnt_sat++;
      if (!OVERLAP) m_bits.delete();
    end
    while (m_bits.size() > 4) void'(m_bits.pop_front());
    m_state = 0;
    for (int k = 3; k >= 1; k--)
      if (tail_is_prefix(k)) begin m_state = k; break; end
  endtask

  task automatic check(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, " match"}, match, m_match);
    check({tag, " match_cnt"}, match_cnt, m_cnt);
    check({tag, " hist"}, hist, m_hist);
    check({tag, " state_o"}, state_o, m_state);
    check({tag, " sat match"}, match_s, m_match);
    check({tag, " sat match_cnt"}, match_cnt_s, m_cnt_sat);
  endtask

  task automatic step(bit d, bit v, bit c, string tag);
    @(negedge clk);
    din = d; din_vld = v; clr = c;
    @(posedge clk);
    model_edge(d, v, c);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit d; bit v; bit c; bit exp_match; int exp_cnt;
  } vec_t;

  vec_t vecs[6];
  int   pulses;
  int   sat_exp[6];
  logic [7:0] hist_save;

  initial begin
    model_reset();
    // Reset held 3 cycles with din toggling and din_vld high.
    din_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); din = ~din;
      @(posedge clk); #1;
      check("reset match", match, 0);
      check("reset cnt", match_cnt, 0);
      check("reset hist", hist, 0);
      check("reset state", state_o, 0);
    end
    @(negedge clk); rst_n = 1'b1; din_vld = 1'b0;
    step(1'b1, 1'b0, 1'b0, "post-reset idle");
    step(1'b0, 1'b0, 1'b0, "post-reset idle");

    // Single pattern via vector table.
    vecs[0] = '{d:0, v:1, c:1, exp_match:0, exp_cnt:0};
    vecs[1] = '{d:1, v:1, c:0, exp_match:0, exp_cnt:0};
    vecs[2] = '{d:1, v:1, c:0, exp_match:0, exp_cnt:0};
    vecs[3] = '{d:0, v:1, c:0, exp_match:0, exp_cnt:0};
    vecs[4] = '{d:1, v:1, c:0, exp_match:1, exp_cnt:1};
    vecs[5] = '{d:0, v:0, c:0, exp_match:0, exp_cnt:1};
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].d, vecs[i].v, vecs[i].c, "table");
      check($sformatf("table[%0d] match", i), match, vecs[i].exp_match);
      check($sformatf("table[%0d] cnt", i), match_cnt, vecs[i].exp_cnt);
    end
    check("single hist[3:0]", hist[3:0], 4'b1101);

    // Overlap: 1101101.
    step(1'b0, 1'b0, 1'b1, "clr");
    pulses = 0;
    foreach (vecs[i]) ;
    for (int i = 0; i < 7; i++) begin
      logic [6:0] seq;
      seq = 7'b1101101;
      step(seq[6 - i], 1'b1, 1'b0, "overlap");
      pulses += match;
    end
    check("overlap pulses", pulses, OVERLAP ? 2 : 1);
    check("overlap cnt", match_cnt, OVERLAP ? 2 : 1);

    // Gaps: 1,1, five idle cycles, 0,1.
    step(1'b0, 1'b0, 1'b1, "clr");
    step(1'b1, 1'b1, 1'b0, "gap");
    step(1'b1, 1'b1, 1'b0, "gap");
    hist_save = hist;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, "gap idle");
      check("gap state S11", state_o, 2);
      check("gap hist held", hist, hist_save);
    end
    step(1'b0, 1'b1, 1'b0, "gap");
    step(1'b1, 1'b1, 1'b0, "gap");
    check("gap match", match, 1);
    check("gap cnt", match_cnt, 1);

    // Saturation on the CNT_W=2 instance: six separated 1101 groups.
    step(1'b0, 1'b0, 1'b1, "clr");
    sat_exp = '{1, 2, 3, 3, 3, 3};
    pulses = 0;
    for (int g = 0; g < 6; g++) begin
      step(1'b1, 1'b1, 1'b0, "sat");
      step(1'b1, 1'b1, 1'b0, "sat");
      step(1'b0, 1'b1, 1'b0, "sat");
      step(1'b1, 1'b1, 1'b0, "sat");
      pulses += match_s;
      check($sformatf("sat cnt group %0d", g), match_cnt_s, sat_exp[g]);
      step(1'b0, 1'b1, 1'b0, "sat sep");
    end
    check("sat pulses", pulses, 6);
    check("wide cnt", match_cnt, 6);

    // clr on the edge of the final 1.
    step(1'b0, 1'b0, 1'b1, "clr");
    step(1'b1, 1'b1, 1'b0, "clrcol");
    step(1'b1, 1'b1, 1'b0, "clrcol");
    step(1'b0, 1'b1, 1'b0, "clrcol");
    step(1'b1, 1'b1, 1'b1, "clrcol");
    check("clrcol match", match, 0);
    check("clrcol cnt", match_cnt, 0);
    check("clrcol state", state_o, 0);

    // Reset after a partial prefix, then a full pattern.
    step(1'b1, 1'b1, 1'b0, "rstcol");
    step(1'b1, 1'b1, 1'b0, "rstcol");
    step(1'b0, 1'b1, 1'b0, "rstcol");
    @(negedge clk); rst_n = 1'b0; din_vld = 1'b0;
    #1; model_reset();
    check("rstcol async state", state_o, 0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] p;
      p = 4'b1101;
      step(p[3 - i], 1'b1, 1'b0, "rstcol");
      pulses += match;
    end
    step(1'b0, 1'b0, 1'b0, "rstcol");
    pulses += match;
    check("rstcol pulses", pulses, 1);

    // Randomized run against the model.
    for (int i = 0; i < 2000; i++) begin
      bit d, v, c;
      d = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      step(d, v, c, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
